// File: rtl/bcd_scan_mux_if.sv
// Bundle of the scan multiplexer's functional signals: control/data in from
// the host side, decoder inputs D..A, anode enables and error flag out.
interface bcd_scan_mux_if #(
    parameter int NDIG = 4
);
    logic              en;
    logic              load;
    logic [4*NDIG-1:0] digits_in;
    logic              D;
    logic              C;
    logic              B;
    logic              A;
    logic [NDIG-1:0]   an;
    logic              err;

    modport master (
        output en, load, digits_in,
        input  D, C, B, A, an, err
    );

    modport slave (
        input  en, load, digits_in,
        output D, C, B, A, an, err
    );
endinterface

// File: rtl/bcd_scan_mux.sv
// Time-multiplexed BCD digit scanner feeding a shared BCD-to-7-segment
// decoder. Holds a shadow copy of the digit bank, steps through the digits
// with a refresh prescaler, keeps anodes dark for a short guard window at the
// start of each slot, blanks leading zeros and darkens non-BCD nibbles.
module bcd_scan_mux #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 1000,
    parameter int GUARD    = 2,
    parameter int LZB      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_scan_mux_if.slave    bus
);
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [3:0]        dcba_q, dcba_d;
    logic              err_q, err_d;

    logic [3:0]        nib     [NDIG];
    logic [NDIG-1:0]   invalid;
    logic [NDIG-1:0]   blank;
    logic              allz;
    logic [3:0]        sel_nib;
    logic              sel_dark;
    logic              guard_ok;

    // Next-state for shadow bank, slot counter and digit index
    always_comb begin
        shadow_d = bus.load ? bus.digits_in : shadow_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        if (bus.en) begin
            if (cnt_q == CNT_W'(PRESCALE - 1)) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Per-digit validity and leading-zero blanking, evaluated on the next shadow
    always_comb begin
        allz = 1'b1;
        for (int k = 0; k < NDIG; k++) begin
            nib[k]     = shadow_d[4*k +: 4];
            invalid[k] = (shadow_d[4*k +: 4] > 4'd9);
        end
        blank = '0;
        // Walk from the most significant digit down; an invalid nibble counts
        // as nonzero and therefore stops the blanking run.
        for (int k = NDIG - 1; k >= 0; k--) begin
            allz     = allz & (nib[k] == 4'd0);
            blank[k] = allz && (k != 0) && (LZB != 0);
        end
    end

    // The guard window is empty when GUARD is 0, so the anode may light at cnt 0
    generate
        if (GUARD == 0) begin : g_noguard
            assign guard_ok = 1'b1;
        end else begin : g_guard
            assign guard_ok = (cnt_d >= CNT_W'(GUARD));
        end
    endgenerate

    assign sel_nib  = nib[idx_d];
    assign sel_dark = blank[idx_d] | invalid[idx_d];

    // Output next-state from next-state cnt/idx/shadow so outputs line up with state
    always_comb begin
        an_d   = '1;
        dcba_d = dcba_q;
        err_d  = |invalid;
        if (bus.en) begin
            dcba_d = sel_dark ? 4'b0000 : sel_nib;
            if (guard_ok && !sel_dark) begin
                an_d[idx_d] = 1'b0;
            end
        end
    end

    // State and registered outputs; reset aborts scanning immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            an_q     <= '1;
            dcba_q   <= 4'b0000;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            dcba_q   <= dcba_d;
            err_q    <= err_d;
        end
    end

    assign bus.D   = dcba_q[3];
    assign bus.C   = dcba_q[2];
    assign bus.B   = dcba_q[1];
    assign bus.A   = dcba_q[0];
    assign bus.an  = an_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_bcd_scan_mux.sv
// Bench for bcd_scan_mux: two instances (leading-zero blanking on and off)
// share the same stimulus; expected outputs are queued per clock and checked
// by an independent monitor on the falling edge.
module tb_bcd_scan_mux;
    logic        clk;
    logic        rst_n;
    logic        en_s;
    logic        load_s;
    logic [15:0] din_s;
    int          ncyc;
    int          total;
    int          bad;

    typedef struct {
        int         stamp;
        bit         which;
        logic [3:0] an;
        logic [3:0] dcba;
        logic       err;
        string      name;
    } exp_t;

    exp_t q[$];

    bcd_scan_mux_if #(.NDIG(4)) if0 ();
    bcd_scan_mux_if #(.NDIG(4)) if1 ();

    assign if0.en        = en_s;
    assign if0.load      = load_s;
    assign if0.digits_in = din_s;
    assign if1.en        = en_s;
    assign if1.load      = load_s;
    assign if1.digits_in = din_s;

    bcd_scan_mux #(.NDIG(4), .PRESCALE(4), .GUARD(1), .LZB(1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    bcd_scan_mux #(.NDIG(4), .PRESCALE(4), .GUARD(1), .LZB(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    // Monitor: pop every expectation due at this cycle and compare
    initial begin
        total = 0;
        bad   = 0;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].stamp <= ncyc) begin
                exp_t e;
                logic [8:0] act;
                logic [8:0] want;
                e = q.pop_front();
                if (e.which)
                    act = {if1.an, if1.D, if1.C, if1.B, if1.A, if1.err};
                else
                    act = {if0.an, if0.D, if0.C, if0.B, if0.A, if0.err};
                want = {e.an, e.dcba, e.err};
                total++;
                if (e.stamp != ncyc) begin
                    bad++;
                    $display("FAIL %s: expectation stale (due cycle %0d, now %0d)", e.name, e.stamp, ncyc);
                end else if (act !== want) begin
                    bad++;
                    $display("FAIL %s: got an=%b dcba=%b err=%b, want an=%b dcba=%b err=%b",
                             e.name, act[8:5], act[4:1], act[0], want[8:5], want[4:1], want[0]);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic step(input bit e, input bit l, input logic [15:0] d, input bit w,
                        input logic [3:0] ean, input logic [3:0] edcba, input logic eerr,
                        input string nm);
        exp_t x;
        en_s   = e;
        load_s = l;
        din_s  = d;
        x.stamp = ncyc + 1;
        x.which = w;
        x.an    = ean;
        x.dcba  = edcba;
        x.err   = eerr;
        x.name  = nm;
        q.push_back(x);
        @(negedge clk);
    endtask

    // One full slot starting at a wrap: guard cycle dark, then three lit cycles
    task automatic run_slot(input bit w, input bit l, input logic [15:0] d,
                            input logic [3:0] an_lit, input logic [3:0] edcba,
                            input logic eerr, input string nm);
        step(1'b1, l, d, w, 4'hF, edcba, eerr, {nm, "_guard"});
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, d, w, an_lit, edcba, eerr, {nm, "_lit"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t x;
        rst_n  = 1'b0;
        en_s   = 1'b0;
        load_s = 1'b0;
        din_s  = 16'h0000;
        @(negedge clk);

        // Reset holds everything; a load during reset is ignored
        step(1'b0, 1'b1, 16'h0305, 1'b0, 4'hF, 4'h0, 1'b0, "reset");
        rst_n = 1'b1;

        // Bank 0305: slot 0 (already past its guard cycle), then 1,2,3,0
        step(1'b1, 1'b1, 16'h0305, 1'b0, 4'hE, 4'h5, 1'b0, "ld0305_s0");
        step(1'b1, 1'b0, 16'h0305, 1'b0, 4'hE, 4'h5, 1'b0, "s0");
        step(1'b1, 1'b0, 16'h0305, 1'b0, 4'hE, 4'h5, 1'b0, "s0");
        run_slot(1'b0, 1'b0, 16'h0305, 4'hD, 4'h0, 1'b0, "s1_zero_shown");
        run_slot(1'b0, 1'b0, 16'h0305, 4'hB, 4'h3, 1'b0, "s2");
        run_slot(1'b0, 1'b0, 16'h0305, 4'hF, 4'h0, 1'b0, "s3_blanked");
        run_slot(1'b0, 1'b0, 16'h0305, 4'hE, 4'h5, 1'b0, "s0_again");

        // All-zero bank loaded on a slot wrap: only digit 0 lights
        run_slot(1'b0, 1'b1, 16'h0000, 4'hF, 4'h0, 1'b0, "z1");
        run_slot(1'b0, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, "z2");
        run_slot(1'b0, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, "z3");
        run_slot(1'b0, 1'b0, 16'h0000, 4'hE, 4'h0, 1'b0, "z0");

        // Invalid nibble in digit 1
        run_slot(1'b0, 1'b1, 16'h12A4, 4'hF, 4'h0, 1'b1, "inv1_dark");
        run_slot(1'b0, 1'b0, 16'h12A4, 4'hB, 4'h2, 1'b1, "inv_d2");
        run_slot(1'b0, 1'b0, 16'h12A4, 4'h7, 4'h1, 1'b1, "inv_d3");
        run_slot(1'b0, 1'b0, 16'h12A4, 4'hE, 4'h4, 1'b1, "inv_d0");
        run_slot(1'b0, 1'b1, 16'h1234, 4'hD, 4'h3, 1'b0, "reload_d1");

        // Walk to idx=1, cnt=2 and then freeze the scan
        run_slot(1'b0, 1'b0, 16'h1234, 4'hB, 4'h2, 1'b0, "b_d2");
        run_slot(1'b0, 1'b0, 16'h1234, 4'h7, 4'h1, 1'b0, "b_d3");
        run_slot(1'b0, 1'b0, 16'h1234, 4'hE, 4'h4, 1'b0, "b_d0");
        step(1'b1, 1'b0, 16'h1234, 1'b0, 4'hF, 4'h3, 1'b0, "b_d1_guard");
        step(1'b1, 1'b0, 16'h1234, 1'b0, 4'hD, 4'h3, 1'b0, "b_d1_c1");
        step(1'b1, 1'b0, 16'h1234, 1'b0, 4'hD, 4'h3, 1'b0, "b_d1_c2");
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, 16'h1234, 1'b0, 4'hF, 4'h3, 1'b0, "hold");
        step(1'b1, 1'b0, 16'h1234, 1'b0, 4'hD, 4'h3, 1'b0, "resume_c3");
        step(1'b1, 1'b0, 16'h1234, 1'b0, 4'hF, 4'h2, 1'b0, "adv_d2_guard");
        step(1'b1, 1'b0, 16'h1234, 1'b0, 4'hB, 4'h2, 1'b0, "d2_c1");
        step(1'b1, 1'b0, 16'h1234, 1'b0, 4'hB, 4'h2, 1'b0, "d2_c2");

        // Asynchronous reset between clock edges during slot 2
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        x.stamp = ncyc;
        x.which = 1'b0;
        x.an    = 4'hF;
        x.dcba  = 4'h0;
        x.err   = 1'b0;
        x.name  = "async_reset";
        q.push_back(x);
        @(negedge clk);
        step(1'b1, 1'b0, 16'h1234, 1'b0, 4'hF, 4'h0, 1'b0, "reset_held");
        rst_n = 1'b1;

        // Restart from idx 0 with a cleared shadow
        step(1'b1, 1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b0, "restart_d0");
        step(1'b1, 1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b0, "restart_d0");
        step(1'b1, 1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b0, "restart_d0");
        run_slot(1'b0, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, "restart_d1");
        run_slot(1'b0, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, "restart_d2");
        run_slot(1'b0, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, "restart_d3");

        // Blanking disabled instance: every anode lights in turn
        run_slot(1'b1, 1'b1, 16'h0007, 4'hE, 4'h7, 1'b0, "nolzb_d0");
        run_slot(1'b1, 1'b0, 16'h0007, 4'hD, 4'h0, 1'b0, "nolzb_d1");
        run_slot(1'b1, 1'b0, 16'h0007, 4'hB, 4'h0, 1'b0, "nolzb_d2");
        run_slot(1'b1, 1'b0, 16'h0007, 4'h7, 4'h0, 1'b0, "nolzb_d3");

        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_scan_mux.md
Name: bcd_scan_mux

Overview:
- Time-multiplexes a bank of NDIG packed BCD digits onto the single D,C,B,A input of the shared BCD-to-7-segment decoder.
- Drives one-hot active-low digit enables (an) in step with the nibble it presents.
- Sits directly upstream of the decoder. Its D,C,B,A outputs wire 1:1 to the decoder inputs; an drives the display common anodes.
- Provides a refresh prescaler, shadow latching of the digit bank, leading-zero blanking and an inter-digit guard (ghost suppression).

Parameters:
- NDIG, 4, number of digits scanned (2..8).
- PRESCALE, 1000, clk cycles per digit slot (>= GUARD+1).
- GUARD, 2, cycles at the start of each slot with all anodes off (0 allowed).
- LZB, 1, 1 = leading-zero blanking enabled, 0 = all digits always shown.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scan enable.
- load  input  1  single-cycle strobe; latches digits_in into the shadow register.
- digits_in  input  4*NDIG  packed BCD; digit k = digits_in[4k+3:4k]; digit 0 = least significant.
- D  output  1  BCD bit 3 (MSB) of the presented digit.
- C  output  1  BCD bit 2.
- B  output  1  BCD bit 1.
- A  output  1  BCD bit 0 (LSB).
- an  output  NDIG  digit enables, active-low, at most one bit low.
- err  output  1  high while the shadow holds any nibble > 9.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: shadow = 0, cnt = 0, idx = 0, an = all 1, D/C/B/A = 0, err = 0. Reset asserted mid-scan aborts immediately; a simultaneous load is ignored.
- State:
  - cnt, slot counter 0..PRESCALE-1, width clog2(PRESCALE).
  - idx, digit index 0..NDIG-1, width clog2(NDIG).
  - shadow, NDIG nibbles.
- Load:
  - load=1 at an edge copies digits_in into shadow, regardless of en.
  - The new value is visible on the outputs from the next cycle, mid-slot if scanning. No slot restart; cnt and idx are unaffected.
- Scan, when en=1 at an edge:
  - If cnt == PRESCALE-1: cnt <= 0 and idx <= (idx == NDIG-1) ? 0 : idx+1.
  - Otherwise cnt <= cnt+1.
  - Order is 0,1,...,NDIG-1,0,...
- Hold, when en=0: cnt and idx hold; an = all 1 from the next cycle; D..A hold their last value.
- Outputs are registered. They are computed from next-state (cnt, idx, shadow, en) so each output matches the state of the same cycle, with no combinational path from inputs to ports.
- D..A: the shadow nibble at idx. It is forced to 0000 if that digit is blanked or invalid.
- an[idx] = 0 only when all of the following hold:
  - en=1;
  - cnt >= GUARD;
  - digit idx is not blanked;
  - digit idx is not invalid.
  - All other an bits are 1.
- Leading-zero blanking (LZB=1):
  - Digit k is blanked if shadow nibbles k..NDIG-1 are all 0000 and k != 0.
  - Digit 0 is never blanked, so an all-zero bank shows a single "0".
  - A zero digit lying below a nonzero digit is shown.
- Invalid nibble (> 9): that digit is dark with D..A = 0000, and err = 1.
  - Invalid nibbles are evaluated for blanking as nonzero.
  - err updates with the shadow and is combinational from shadow via a register.
- Simultaneous load and slot wrap: both take effect on the same edge, and the new slot uses the new shadow.
- Slot timing: a slot lasts exactly PRESCALE cycles and a full frame NDIG*PRESCALE cycles. The anode is low for PRESCALE-GUARD cycles per slot.

Test Plan:
- Test parameters: NDIG=4, PRESCALE=4, GUARD=1, LZB=1 unless stated.
- Reset then load digits_in=16'h0305, en=1 -> idx sequence 0,1,2,3 every 4 cycles, presenting:
  - slot 0: DCBA=0101, an=1110 for cycles 2-4 of the slot, 1111 in cycle 1;
  - slot 1: DCBA=0000, an=1101;
  - slot 2: DCBA=0011, an=1011;
  - slot 3: blanked, an=1111, DCBA=0000.
- Load 16'h0000 -> only digit 0 lit (an=1110, DCBA=0000 in slot 0); slots 1-3 have an=1111; err=0.
- Load 16'h12A4 -> err=1 the cycle after load.
  - Slot 1 dark with DCBA=0000.
  - Digits 0, 2 and 3 show 4, 2 and 1.
  - Reload 16'h1234 -> err=0 next cycle.
- Drop en for 10 cycles mid-slot (cnt=2, idx=1) -> an=1111 and cnt/idx frozen; on re-enable the slot resumes at cnt=3 and idx advances after 1 more cycle.
- Assert rst_n=0 asynchronously mid-cycle during slot 2 -> an=1111, DCBA=0000 and err=0 immediately, without waiting for clk; after release, scanning restarts at idx=0 with shadow=0.
- LZB=0, load 16'h0007 -> all four anodes cycle low in turn, with DCBA=0111 in slot 0 and 0000 in slots 1-3.
